// File: rtl/tiger_ckpt_ctrl.sv
// Checkpoint/rollback sequencer for the Tiger pipeline.
// On a power-loss warning it drains Ex/MA/WB, streams the architectural state
// out to NVM, then holds the core off; on power return it streams the state
// back in under zstall and releases the pipeline.
// Build option: define CKPT_PERIODIC_EN to also take periodic checkpoints
// every PERIOD idle cycles (these return to IDLE instead of powering off).
module tiger_ckpt_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned SAVE_WORDS   = 35
`ifdef CKPT_PERIODIC_EN
    ,
    parameter int unsigned PERIOD       = 1024
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       powerLow,
    input  logic       powerGood,
    input  logic       stallMA,
    input  logic       stallWB,
    input  logic       saveAck,
    input  logic       restoreAck,
    output logic       checkpoint,
    output logic       checkpointing,
    output logic       poweroff,
    output logic       zstall,
    output logic       saveReq,
    output logic       restoreReq,
    output logic [5:0] wordIdx,
    output logic       ckptValid
);

    localparam int unsigned   DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [5:0]    LAST_WORD  = 6'(SAVE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StSave,
        StOff,
        StRestore,
        StResume
    } state_e;

    state_e        r_state, w_state_d;
    logic          r_shutdown, w_shutdown_d;
    logic [DW-1:0] r_drain_cnt, w_drain_cnt_d;
    logic [5:0]    r_word_idx, w_word_idx_d;
    logic          r_ckpt_valid, w_ckpt_valid_d;
    logic          r_checkpoint, w_checkpoint_d;
    logic          w_no_stall;
    logic          w_start_ckpt;

    assign w_no_stall = !stallMA && !stallWB;

`ifdef CKPT_PERIODIC_EN
    logic [15:0] r_period_cnt, w_period_cnt_d;
    logic        w_period_hit;

    assign w_period_hit = (r_period_cnt == 16'(PERIOD - 1));
    assign w_start_ckpt = powerLow || w_period_hit;

    // Idle-cycle counter: runs only while staying in IDLE, zero otherwise.
    always_comb begin
        w_period_cnt_d = '0;
        if (r_state == StIdle && w_state_d == StIdle) begin
            w_period_cnt_d = r_period_cnt + 16'd1;
        end
    end

    // Periodic counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= w_period_cnt_d;
        end
    end
`else
    assign w_start_ckpt = powerLow;
`endif

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        w_state_d      = r_state;
        w_shutdown_d   = r_shutdown;
        w_drain_cnt_d  = r_drain_cnt;
        w_word_idx_d   = r_word_idx;
        w_ckpt_valid_d = r_ckpt_valid;
        w_checkpoint_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_ckpt) begin
                    w_state_d     = StDrain;
                    // A periodic checkpoint keeps shutdown clear unless powerLow coincides.
                    w_shutdown_d  = powerLow;
                    w_drain_cnt_d = DRAIN_LOAD;
                end
            end
            StDrain: begin
                if (powerLow) begin
                    w_shutdown_d = 1'b1;
                end
                // Leave on the cycle the count would reach zero so DRAIN lasts
                // exactly DRAIN_CYCLES stall-free cycles.
                if (r_drain_cnt == '0 || (w_no_stall && r_drain_cnt == DW'(1))) begin
                    w_state_d      = StSave;
                    w_drain_cnt_d  = '0;
                    w_word_idx_d   = '0;
                    w_ckpt_valid_d = 1'b0;
                    w_checkpoint_d = 1'b1;
                end else if (w_no_stall) begin
                    w_drain_cnt_d = r_drain_cnt - DW'(1);
                end
            end
            StSave: begin
                if (powerLow) begin
                    w_shutdown_d = 1'b1;
                end
                if (saveAck) begin
                    if (r_word_idx == LAST_WORD) begin
                        w_ckpt_valid_d = 1'b1;
                        w_word_idx_d   = '0;
                        w_state_d      = (r_shutdown || powerLow) ? StOff : StIdle;
                    end else begin
                        w_word_idx_d = r_word_idx + 6'd1;
                    end
                end
            end
            StOff: begin
                if (powerGood && !powerLow) begin
                    if (r_ckpt_valid) begin
                        w_state_d    = StRestore;
                        w_word_idx_d = '0;
                    end else begin
                        w_state_d    = StIdle;
                        w_shutdown_d = 1'b0;
                    end
                end
            end
            StRestore: begin
                // Abort wins over an ack; the held checkpoint is replayed from word 0.
                if (powerLow) begin
                    w_state_d    = StOff;
                    w_word_idx_d = '0;
                end else if (restoreAck) begin
                    if (r_word_idx == LAST_WORD) begin
                        w_state_d    = StResume;
                        w_word_idx_d = '0;
                    end else begin
                        w_word_idx_d = r_word_idx + 6'd1;
                    end
                end
            end
            StResume: begin
                w_state_d    = StIdle;
                w_shutdown_d = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; ckptValid is volatile across reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_shutdown   <= 1'b0;
            r_drain_cnt  <= '0;
            r_word_idx   <= '0;
            r_ckpt_valid <= 1'b0;
            r_checkpoint <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shutdown   <= w_shutdown_d;
            r_drain_cnt  <= w_drain_cnt_d;
            r_word_idx   <= w_word_idx_d;
            r_ckpt_valid <= w_ckpt_valid_d;
            r_checkpoint <= w_checkpoint_d;
        end
    end

    assign checkpoint    = r_checkpoint;
    assign checkpointing = (r_state == StDrain) || (r_state == StSave);
    assign poweroff      = (r_state == StOff);
    assign zstall        = (r_state == StRestore) || (r_state == StResume);
    assign saveReq       = (r_state == StSave);
    assign restoreReq    = (r_state == StRestore);
    assign wordIdx       = r_word_idx;
    assign ckptValid     = r_ckpt_valid;

endmodule

// File: tb/tb_tiger_ckpt_ctrl.sv
// Scoreboard bench for tiger_ckpt_ctrl: stimulus pushes expected events
// (kind, value, cycle) and a negedge monitor pops and compares them.
module tb_tiger_ckpt_ctrl;

    localparam int DRAIN     = 4;
    localparam int SAVEW     = 35;
    localparam int PERIOD_TB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       powerLow = 1'b0;
    logic       powerGood = 1'b0;
    logic       stallMA = 1'b0;
    logic       stallWB = 1'b0;
    logic       saveAck = 1'b0;
    logic       restoreAck = 1'b0;
    logic       checkpoint, checkpointing, poweroff, zstall;
    logic       saveReq, restoreReq, ckptValid;
    logic [5:0] wordIdx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tiger_ckpt_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .SAVE_WORDS(SAVEW)
`ifdef CKPT_PERIODIC_EN
        ,
        .PERIOD(PERIOD_TB)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .powerLow(powerLow),
        .powerGood(powerGood),
        .stallMA(stallMA),
        .stallWB(stallWB),
        .saveAck(saveAck),
        .restoreAck(restoreAck),
        .checkpoint(checkpoint),
        .checkpointing(checkpointing),
        .poweroff(poweroff),
        .zstall(zstall),
        .saveReq(saveReq),
        .restoreReq(restoreReq),
        .wordIdx(wordIdx),
        .ckptValid(ckptValid)
    );

    typedef enum int {EvCkpt, EvSave, EvOffRise, EvZRise, EvRest, EvZFall, EvValid} ev_e;
    typedef struct {
        ev_e kind;
        int  val;
        int  cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic p_off = 1'b0;
    logic p_z = 1'b0;
    logic p_valid = 1'b0;

    function automatic void push(input ev_e k, input int v, input int c);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic observe(input ev_e k, input int v);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got val=%0d at cyc=%0d, required no event",
                     k.name(), v, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                bad++;
                $display("FAIL event_%s: got %s val=%0d cyc=%0d, required %s val=%0d cyc=%0d",
                         e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    function automatic int outs();
        logic [12:0] v;
        v = {checkpoint, checkpointing, poweroff, zstall, saveReq, restoreReq, ckptValid,
             wordIdx};
        return int'(v);
    endfunction

    // Advance to 1 time unit after the posedge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: fixed in-cycle order ckpt, save, offrise, zrise, rest, zfall, valid.
    always @(negedge clk) begin
        if (reset_n) begin
            if (checkpoint) observe(EvCkpt, 1);
            if (saveReq && saveAck) observe(EvSave, int'(wordIdx));
            if (poweroff && !p_off) observe(EvOffRise, 1);
            if (zstall && !p_z) observe(EvZRise, 1);
            if (restoreReq && restoreAck) observe(EvRest, int'(wordIdx));
            if (!zstall && p_z) observe(EvZFall, 1);
            if (ckptValid != p_valid) observe(EvValid, int'(ckptValid));
        end
        p_off   <= poweroff;
        p_z     <= zstall;
        p_valid <= ckptValid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish by 100000");
        $fatal(1);
    end

    initial begin
        int k;
        int m;
        int r;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        goto(cyc + 1);
        reset_n = 1'b1;
        r = cyc;

`ifdef CKPT_PERIODIC_EN
        // 16 idle cycles, then a non-shutdown checkpoint that returns to IDLE.
        saveAck = 1'b1;
        push(EvCkpt, 1, r + PERIOD_TB + DRAIN);
        for (int i = 0; i < SAVEW; i++) push(EvSave, i, r + PERIOD_TB + DRAIN + i);
        push(EvValid, 1, r + PERIOD_TB + DRAIN + SAVEW);
        goto(r + PERIOD_TB - 1);
        @(negedge clk);
        check("periodic_still_idle", int'(checkpointing), 0);
        goto(r + PERIOD_TB);
        @(negedge clk);
        check("periodic_drain", int'(checkpointing), 1);
        goto(r + PERIOD_TB + DRAIN + SAVEW + 2);
        @(negedge clk);
        check("periodic_no_poweroff", int'(poweroff), 0);
        check("periodic_back_idle", int'(checkpointing), 0);
        check("periodic_valid", int'(ckptValid), 1);
        goto(cyc + 1);
        reset_n = 1'b0;
`else
        // Reset in the middle of SAVE (no acks) drops everything.
        goto(r + 1);
        k = cyc;
        powerLow = 1'b1;
        push(EvCkpt, 1, k + 1 + DRAIN);
        goto(k + 1);
        powerLow = 1'b0;
        @(negedge clk);
        check("ckpting_next_cycle", int'(checkpointing), 1);
        goto(k + 1 + DRAIN + 3);
        @(negedge clk);
        check("save_held", int'({saveReq, checkpointing, checkpoint}), 6);
        goto(cyc + 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_save", outs(), 0);
        goto(cyc + 2);
        reset_n = 1'b1;
        @(negedge clk);
        check("after_reset", outs(), 0);

        // Clean shutdown, saveAck tied high.
        goto(cyc + 2);
        k = cyc;
        saveAck = 1'b1;
        powerLow = 1'b1;
        push(EvCkpt, 1, k + 1 + DRAIN);
        for (int i = 0; i < SAVEW; i++) push(EvSave, i, k + 1 + DRAIN + i);
        push(EvOffRise, 1, k + 1 + DRAIN + SAVEW);
        push(EvValid, 1, k + 1 + DRAIN + SAVEW);
        @(negedge clk);
        check("idle_not_ckpting", int'(checkpointing), 0);
        goto(k + 1);
        powerLow = 1'b0;
        goto(k + 2 + DRAIN + SAVEW);
        @(negedge clk);
        check("off_outputs", int'({poweroff, checkpointing, saveReq, zstall}), 8);

        // Restore with restoreAck every other cycle.
        goto(cyc + 1);
        m = cyc;
        powerGood = 1'b1;
        push(EvZRise, 1, m + 1);
        for (int i = 0; i < SAVEW; i++) push(EvRest, i, m + 2 + 2 * i);
        push(EvZFall, 1, m + 2 * SAVEW + 2);
        for (int c = m + 1; c <= m + 2 * SAVEW; c++) begin
            goto(c);
            restoreAck = ((c - m) % 2 == 0);
        end
        goto(m + 2 * SAVEW + 1);
        restoreAck = 1'b0;
        @(negedge clk);
        check("resume_cycle", int'({zstall, restoreReq}), 2);
        goto(m + 2 * SAVEW + 2);
        powerGood = 1'b0;
        @(negedge clk);
        check("idle_after_resume", int'({zstall, checkpointing, poweroff}), 0);
        check("valid_after_restore", int'(ckptValid), 1);

        // Drain with 3 stallMA cycles plus 1 stallWB cycle: checkpoint 4 cycles late.
        goto(cyc + 1);
        k = cyc;
        powerLow = 1'b1;
        push(EvCkpt, 1, k + 1 + DRAIN + 4);
        push(EvSave, 0, k + 1 + DRAIN + 4);
        push(EvValid, 0, k + 1 + DRAIN + 4);
        for (int i = 1; i < SAVEW; i++) push(EvSave, i, k + 1 + DRAIN + 4 + i);
        push(EvOffRise, 1, k + 1 + DRAIN + 4 + SAVEW);
        push(EvValid, 1, k + 1 + DRAIN + 4 + SAVEW);
        goto(k + 1);
        powerLow = 1'b0;
        goto(k + 2);
        stallMA = 1'b1;
        goto(k + 5);
        stallMA = 1'b0;
        goto(k + 6);
        stallWB = 1'b1;
        goto(k + 7);
        stallWB = 1'b0;
        @(negedge clk);
        check("still_draining", int'({checkpointing, saveReq}), 2);
        goto(k + 2 + DRAIN + 4 + SAVEW);

        // Restore aborted at wordIdx 10, then replayed from word 0.
        m = cyc;
        powerGood = 1'b1;
        restoreAck = 1'b1;
        push(EvZRise, 1, m + 1);
        for (int i = 0; i < 10; i++) push(EvRest, i, m + 1 + i);
        goto(m + 11);
        restoreAck = 1'b0;
        powerLow = 1'b1;
        powerGood = 1'b0;
        push(EvOffRise, 1, m + 12);
        push(EvZFall, 1, m + 12);
        @(negedge clk);
        check("abort_point_idx", int'(wordIdx), 10);
        goto(m + 12);
        @(negedge clk);
        check("abort_poweroff", int'(poweroff), 1);
        check("abort_valid_kept", int'(ckptValid), 1);
        goto(m + 14);
        powerLow = 1'b0;
        powerGood = 1'b1;
        restoreAck = 1'b1;
        push(EvZRise, 1, m + 15);
        for (int i = 0; i < SAVEW; i++) push(EvRest, i, m + 15 + i);
        push(EvZFall, 1, m + 16 + SAVEW);
        goto(m + 15);
        @(negedge clk);
        check("replay_from_zero", int'(wordIdx), 0);
        goto(m + 15 + SAVEW);
        restoreAck = 1'b0;
        @(negedge clk);
        check("replay_resume", int'({zstall, restoreReq}), 2);
        goto(m + 16 + SAVEW);
        powerGood = 1'b0;
        @(negedge clk);
        check("replay_idle", int'(zstall), 0);
`endif

        goto(cyc + 3);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
